// File: rtl/mem_io_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_io_pkg
// Description : Shared types and address map for the data-memory / MMIO
//               arbiter and the peripherals that reuse its address decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_io_pkg;

  localparam logic [31:0] c_io_base  = 32'hFFFF_FC00;
  localparam logic [31:0] c_sw_addr  = 32'hFFFF_FC60;
  localparam logic [31:0] c_led_addr = 32'hFFFF_FC62;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RESP    = 2'd2,
    S_UPG     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MEM = 2'd0,
    SW  = 2'd1,
    LED = 2'd2,
    BAD = 2'd3
  } addr_class_t;

  // Loader word counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : mem_io_arbiter_if
// Description : CPU, program-loader, data-memory and switch/LED signals seen
//               by the arbiter. slave = arbiter side, master = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_io_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              upg_mode;
  logic              cpu_req;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              upg_req;
  logic [DATA_W-1:0] upg_addr;
  logic [DATA_W-1:0] upg_wdata;
  logic              upg_ready;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       sw_data;
  logic              sw_cs;
  logic              led_cs;
  logic [DATA_W-1:0] io_wdata;
  logic              owner;
  logic [15:0]       upg_words;
  logic              io_err;

  modport slave (
    input  upg_mode, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  upg_req, upg_addr, upg_wdata, mem_rdata, sw_data,
    output cpu_rdata, cpu_ready, upg_ready, mem_en, mem_we, mem_addr,
    output mem_wdata, sw_cs, led_cs, io_wdata, owner, upg_words, io_err
  );

  modport master (
    output upg_mode, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output upg_req, upg_addr, upg_wdata, mem_rdata, sw_data,
    input  cpu_rdata, cpu_ready, upg_ready, mem_en, mem_we, mem_addr,
    input  mem_wdata, sw_cs, led_cs, io_wdata, owner, upg_words, io_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_io_arbiter_io_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : io_addr_decode
// Description : Combinational address classifier: plain memory, switch
//               register, LED register, or unmapped MMIO.
// Revision    : 1.0 - initial release
// ============================================================================
module io_addr_decode
  import mem_io_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] IO_BASE  = c_io_base,
  parameter logic [DATA_W-1:0] SW_ADDR  = c_sw_addr,
  parameter logic [DATA_W-1:0] LED_ADDR = c_led_addr
) (
  input  logic [DATA_W-1:0] i_addr,
  output addr_class_t       o_class
);

  // Everything below IO_BASE is memory; inside the MMIO window only the two
  // peripheral registers are mapped.
  always_comb begin
    o_class = BAD;
    if (i_addr < IO_BASE) begin
      o_class = MEM;
    end else if (i_addr == SW_ADDR) begin
      o_class = SW;
    end else if (i_addr == LED_ADDR) begin
      o_class = LED;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_arbiter
// Description : Sequences CPU loads/stores to data memory and MMIO, and hands
//               the memory port to the UART program loader while upg_mode is
//               high. The CPU is stalled (no cpu_ready) during loader sessions.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_arbiter
  import mem_io_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] IO_BASE  = c_io_base,
  parameter logic [DATA_W-1:0] SW_ADDR  = c_sw_addr,
  parameter logic [DATA_W-1:0] LED_ADDR = c_led_addr,
  parameter int                RD_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_io_arbiter_if.slave  bus
);

  localparam logic [1:0] c_rd_lat = 2'(RD_LAT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_rd_cnt;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_upg_pend;
  logic [15:0]       r_upg_words;
  logic              r_io_err;

  addr_class_t       w_cpu_cls;
  addr_class_t       w_upg_cls;

  logic              w_mem_en;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_sw_cs;
  logic              w_led_cs;
  logic [DATA_W-1:0] w_io_wdata;
  logic              w_cpu_ready;
  logic              w_upg_ready;
  logic              w_lat_load;
  logic              w_cap_sw;
  logic              w_cap_mem;
  logic              w_cap_zero;
  logic              w_upg_issue;
  logic              w_upg_enter;
  logic              w_set_err;

  io_addr_decode #(
    .DATA_W   (DATA_W),
    .IO_BASE  (IO_BASE),
    .SW_ADDR  (SW_ADDR),
    .LED_ADDR (LED_ADDR)
  ) u_cpu_dec (
    .i_addr  (bus.cpu_addr),
    .o_class (w_cpu_cls)
  );

  io_addr_decode #(
    .DATA_W   (DATA_W),
    .IO_BASE  (IO_BASE),
    .SW_ADDR  (SW_ADDR),
    .LED_ADDR (LED_ADDR)
  ) u_upg_dec (
    .i_addr  (bus.upg_addr),
    .o_class (w_upg_cls)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and issue-cycle strobes; memory/IO strobes exist only in the
  // cycle an access is issued.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_sw_cs     = 1'b0;
    w_led_cs    = 1'b0;
    w_io_wdata  = '0;
    w_cpu_ready = 1'b0;
    w_upg_ready = 1'b0;
    w_lat_load  = 1'b0;
    w_cap_sw    = 1'b0;
    w_cap_mem   = 1'b0;
    w_cap_zero  = 1'b0;
    w_upg_issue = 1'b0;
    w_upg_enter = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.upg_mode) begin
          // Loader wins a tie with a CPU request; the CPU simply waits.
          w_upg_enter = 1'b1;
          w_state_nxt = S_UPG;
        end else if (bus.cpu_req) begin
          w_state_nxt = S_RESP;
          if (w_cpu_cls == MEM) begin
            w_mem_en   = 1'b1;
            w_mem_we   = bus.cpu_we;
            w_mem_addr = bus.cpu_addr;
            if (bus.cpu_we) begin
              w_mem_wdata = bus.cpu_wdata;
            end else begin
              w_lat_load  = 1'b1;
              w_state_nxt = S_RD_WAIT;
            end
          end else if (w_cpu_cls == SW && !bus.cpu_we) begin
            w_sw_cs  = 1'b1;
            w_cap_sw = 1'b1;
          end else if (w_cpu_cls == LED && bus.cpu_we) begin
            w_led_cs   = 1'b1;
            w_io_wdata = bus.cpu_wdata;
          end else begin
            // Unmapped register or wrong direction (store to switches,
            // load from LEDs): complete with zero data and flag it.
            w_cap_zero = 1'b1;
            w_set_err  = 1'b1;
          end
        end
      end
      S_RD_WAIT: begin
        if (r_rd_cnt == 2'd1) begin
          w_cap_mem   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_cpu_ready = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_UPG: begin
        if (r_upg_pend) begin
          // Completion of the write issued last cycle; exit is re-evaluated
          // afterwards so a pending write always finishes.
          w_upg_ready = 1'b1;
        end else if (!bus.upg_mode) begin
          w_state_nxt = S_IDLE;
        end else if (bus.upg_req) begin
          w_upg_issue = 1'b1;
          if (w_upg_cls == MEM) begin
            w_mem_en    = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = bus.upg_addr;
            w_mem_wdata = bus.upg_wdata;
          end else begin
            // The loader must never touch peripherals: drop and flag.
            w_set_err = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers: read-latency counter, load data, loader bookkeeping
  // and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_cnt    <= 2'd0;
      r_cpu_rdata <= '0;
      r_upg_pend  <= 1'b0;
      r_upg_words <= 16'd0;
      r_io_err    <= 1'b0;
    end else begin
      if (w_lat_load) begin
        r_rd_cnt <= c_rd_lat;
      end else if (r_state == S_RD_WAIT) begin
        r_rd_cnt <= r_rd_cnt - 2'd1;
      end

      if (w_cap_sw) begin
        r_cpu_rdata <= {{(DATA_W-16){1'b0}}, bus.sw_data};
      end else if (w_cap_mem) begin
        r_cpu_rdata <= bus.mem_rdata;
      end else if (w_cap_zero) begin
        r_cpu_rdata <= '0;
      end

      if (w_upg_issue) begin
        r_upg_pend <= 1'b1;
      end else if (w_upg_ready) begin
        r_upg_pend <= 1'b0;
      end

      if (w_upg_enter) begin
        r_upg_words <= 16'd0;
      end else if (w_upg_ready) begin
        r_upg_words <= sat_inc16(r_upg_words);
      end

      if (w_set_err) begin
        r_io_err <= 1'b1;
      end
    end
  end

  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.sw_cs     = w_sw_cs;
  assign bus.led_cs    = w_led_cs;
  assign bus.io_wdata  = w_io_wdata;
  assign bus.cpu_ready = w_cpu_ready;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.upg_ready = w_upg_ready;
  assign bus.owner     = (r_state == S_UPG);
  assign bus.upg_words = r_upg_words;
  assign bus.io_err    = r_io_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_arbiter
// Description : Scoreboard bench for mem_io_arbiter: drivers push expected
//               completions, a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_arbiter;

  localparam int          RD_LAT   = 1;
  localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;
  localparam logic [31:0] SW_ADDR  = 32'hFFFF_FC60;
  localparam logic [31:0] LED_ADDR = 32'hFFFF_FC62;
  localparam logic [31:0] BAD_ADDR = 32'hFFFF_FC70;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_io_arbiter_if #(.DATA_W(32)) bus ();

  mem_io_arbiter #(.DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          at;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  exp_t        q_cpu[$];
  exp_t        q_upg[$];
  exp_t        q_led[$];
  exp_t        q_sw[$];
  logic [31:0] dev_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] rd_hold;
  bit          rd_valid = 1'b0;
  bit          exp_err = 1'b0;
  logic [15:0] exp_words = 16'd0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void chk_evt(input string nm, input bit have, input exp_t e, input logic [31:0] act);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s: unexpected pulse at cycle %0d, required none", nm, cyc);
    end else if (cyc != e.at || (e.chk_data && act !== e.data)) begin
      errors++;
      $display("FAIL %s: got cycle %0d data %h, required cycle %0d data %h", nm, cyc, act, e.at, e.data);
    end
  endfunction

  // Block-RAM device: a read issued in cycle T shows its data only during
  // cycle T+1; at all other times the read bus carries noise.
  always @(negedge clk) begin
    bus.mem_rdata = rd_valid ? rd_hold : $urandom;
    rd_valid = 1'b0;
    if (bus.mem_en && !bus.mem_we) begin
      rd_hold  = dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr] : dflt(bus.mem_addr);
      rd_valid = 1'b1;
    end
    if (bus.mem_en && bus.mem_we) dev_mem[bus.mem_addr] = bus.mem_wdata;
  end

  // Monitor: every completion or chip-select pulse must match a queued entry.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (bus.cpu_ready) begin
      have = (q_cpu.size() > 0);
      if (have) e = q_cpu.pop_front();
      chk_evt("cpu_ready", have, e, bus.cpu_rdata);
    end
    if (bus.upg_ready) begin
      have = (q_upg.size() > 0);
      if (have) e = q_upg.pop_front();
      chk_evt("upg_ready", have, e, 32'd0);
    end
    if (bus.led_cs) begin
      have = (q_led.size() > 0);
      if (have) e = q_led.pop_front();
      chk_evt("led_cs", have, e, bus.io_wdata);
    end
    if (bus.sw_cs) begin
      have = (q_sw.size() > 0);
      if (have) e = q_sw.pop_front();
      chk_evt("sw_cs", have, e, 32'd0);
    end
  end

  task automatic wait_pulse(input bit upg, input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!done) begin
        @(negedge clk);
        done = upg ? bus.upg_ready : bus.cpu_ready;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no pulse within 24 cycles, required one", nm);
    end
  endtask

  task automatic cpu_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [15:0] sw);
    exp_t e;
    bit   is_mem, is_sw, is_led;
    @(posedge clk); #1;
    bus.sw_data   = sw;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.cpu_req   = 1'b1;
    is_mem = (addr < IO_BASE);
    is_sw  = (addr == SW_ADDR) && !we;
    is_led = (addr == LED_ADDR) && we;
    e.at       = cyc + ((is_mem && !we) ? RD_LAT + 1 : 1);
    e.chk_data = !we;
    e.data     = 32'd0;
    if (is_mem) begin
      e.data = ref_rd(addr);
      if (we) ref_mem[addr] = wd;
    end else if (is_sw) begin
      e.data = {16'h0, sw};
      q_sw.push_back('{cyc, 32'd0, 1'b0});
    end else if (is_led) begin
      q_led.push_back('{cyc, wd, 1'b1});
    end else begin
      exp_err = 1'b1;
    end
    q_cpu.push_back(e);
    @(negedge clk);
    chk("mem_en@issue", 32'(bus.mem_en), 32'(is_mem));
    chk("mem_we@issue", 32'(bus.mem_we), 32'(is_mem && we));
    wait_pulse(1'b0, "cpu_ready");
    chk("io_err", 32'(bus.io_err), 32'(exp_err));
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic upg_write(input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk); #1;
    bus.upg_addr  = addr;
    bus.upg_wdata = wd;
    bus.upg_req   = 1'b1;
    q_upg.push_back('{cyc + 1, 32'd0, 1'b0});
    if (addr < IO_BASE) ref_mem[addr] = wd;
    else exp_err = 1'b1;
    exp_words = (exp_words == 16'hFFFF) ? exp_words : exp_words + 16'd1;
    wait_pulse(1'b1, "upg_ready");
    @(posedge clk); #1;
    bus.upg_req = 1'b0;
  endtask

  task automatic upg_enter();
    @(posedge clk); #1;
    bus.upg_mode = 1'b1;
    exp_words = 16'd0;
    @(posedge clk);
    @(negedge clk);
    chk("owner@enter", 32'(bus.owner), 32'd1);
    chk("upg_words@enter", 32'(bus.upg_words), 32'd0);
  endtask

  task automatic upg_leave();
    @(posedge clk); #1;
    bus.upg_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("owner@leave", 32'(bus.owner), 32'd0);
    chk("upg_words@leave", 32'(bus.upg_words), 32'(exp_words));
    chk("io_err@leave", 32'(bus.io_err), 32'(exp_err));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".cpu_rdata"}, bus.cpu_rdata, 32'd0);
    chk({nm, ".cpu_ready"}, 32'(bus.cpu_ready), 32'd0);
    chk({nm, ".upg_ready"}, 32'(bus.upg_ready), 32'd0);
    chk({nm, ".mem_en"}, 32'(bus.mem_en), 32'd0);
    chk({nm, ".cs"}, 32'({bus.sw_cs, bus.led_cs}), 32'd0);
    chk({nm, ".owner"}, 32'(bus.owner), 32'd0);
    chk({nm, ".upg_words"}, 32'(bus.upg_words), 32'd0);
    chk({nm, ".io_err"}, 32'(bus.io_err), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    bus.upg_mode = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.upg_req = 1'b0;
    bus.upg_addr = '0; bus.upg_wdata = '0; bus.sw_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Memory load with one-cycle RAM latency
    dev_mem[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10] = 32'hDEAD_BEEF;
    cpu_access(1'b0, 32'h10, 32'h0, 16'h0);

    // LED store, switch load, unmapped MMIO load (sticky error)
    cpu_access(1'b1, LED_ADDR, 32'h0000_A5A5, 16'h0);
    cpu_access(1'b0, SW_ADDR, 32'h0, 16'h1234);
    cpu_access(1'b0, BAD_ADDR, 32'h0, 16'h0);
    cpu_access(1'b1, 32'h20, 32'h1111_2222, 16'h0);
    cpu_access(1'b0, 32'h20, 32'h0, 16'h0);

    // Reset during the read-wait state aborts the load silently
    @(posedge clk); #1;
    bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20; bus.cpu_req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err = 1'b0; exp_words = 16'd0;
    @(negedge clk);
    chk_all_zero("abort");
    repeat (4) @(posedge clk);

    // Loader request arriving during an in-flight CPU load
    @(posedge clk); #1;
    bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10; bus.cpu_req = 1'b1;
    q_cpu.push_back('{cyc + RD_LAT + 1, ref_rd(32'h10), 1'b1});
    @(posedge clk); #1;
    bus.upg_mode = 1'b1;
    wait_pulse(1'b0, "cpu_ready");
    @(posedge clk); #1;
    bus.cpu_addr = 32'h104;
    @(posedge clk);
    @(negedge clk);
    chk("owner@handoff", 32'(bus.owner), 32'd1);
    chk("upg_words@handoff", 32'(bus.upg_words), 32'd0);
    exp_words = 16'd0;
    upg_write(32'h100, 32'hCAFE_0100);
    upg_write(32'h104, 32'hCAFE_0104);
    upg_write(LED_ADDR, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("upg_words=3", 32'(bus.upg_words), 32'd3);
    @(posedge clk); #1;
    bus.upg_mode = 1'b0;
    q_cpu.push_back('{cyc + 1 + RD_LAT + 1, ref_rd(32'h104), 1'b1});
    wait_pulse(1'b0, "cpu_ready");
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("owner@release", 32'(bus.owner), 32'd0);
    chk("upg_words@hold", 32'(bus.upg_words), 32'd3);
    chk("io_err@upg_mmio", 32'(bus.io_err), 32'(exp_err));
    cpu_access(1'b0, 32'h100, 32'h0, 16'h0);

    // Randomized mix of CPU traffic and loader sessions
    for (int n = 0; n < 60; n++) begin
      int          r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      a = 32'h40 + 32'(4 * $urandom_range(0, 7));
      if (r <= 4) begin
        cpu_access(1'($urandom), a, $urandom, 16'($urandom));
      end else if (r == 5) begin
        cpu_access(1'b0, SW_ADDR, 32'h0, 16'($urandom));
      end else if (r == 6) begin
        cpu_access(1'b1, LED_ADDR, $urandom, 16'($urandom));
      end else if (r == 7) begin
        case ($urandom_range(0, 3))
          0:       cpu_access(1'b0, BAD_ADDR, 32'h0, 16'($urandom));
          1:       cpu_access(1'b0, LED_ADDR, 32'h0, 16'($urandom));
          2:       cpu_access(1'b1, SW_ADDR, $urandom, 16'($urandom));
          default: cpu_access(1'b1, IO_BASE + 32'h8, $urandom, 16'($urandom));
        endcase
      end else begin
        upg_enter();
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          if ($urandom_range(0, 7) == 0) upg_write(SW_ADDR, $urandom);
          else upg_write(32'h40 + 32'(4 * $urandom_range(0, 7)), $urandom);
        end
        upg_leave();
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    chk("q_cpu_drained", 32'(q_cpu.size()), 32'd0);
    chk("q_upg_drained", 32'(q_upg.size()), 32'd0);
    chk("q_io_drained", 32'(q_led.size() + q_sw.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
